// File: rtl/mask_arb_pkg.sv
// Shared types and helpers for the mask_arb round-robin arbiter.
package mask_arb_pkg;

  typedef enum logic {IDLE, GRANT} state_t;

  // Minimum-1 clog2 rule used for the grant index width.
  function automatic int idx_w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

  // Reset pointer position: the top requester, so index 0 has priority first.
  function automatic int rst_ptr_pos(input int w);
    return w - 1;
  endfunction

  function automatic logic [63:0] lsb_onehot(input logic [63:0] v);
    return v & (~v + 64'd1);
  endfunction

  function automatic logic [5:0] onehot_enc(input logic [63:0] v);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (v[i]) r = r | 6'(i);
    return r;
  endfunction

endpackage

// File: rtl/mask_arb_sel.sv
// Combinational round-robin pick: lowest request strictly above ptr, else lowest overall.
module mask_arb_sel
  import mask_arb_pkg::*;
#(
  parameter int W     = 4,
  parameter int IDX_W = idx_w(W)
) (
  input  logic [W-1:0]     i_req,
  input  logic [W-1:0]     ptr,
  output logic [W-1:0]     pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_vld
);

  logic [63:0] req64, ptr64, above, hi, pick64;

  always_comb begin
    req64  = 64'(i_req);
    ptr64  = 64'(ptr);
    // One-hot ptr: everything at or below the ptr bit is cleared.
    above  = ~(ptr64 | (ptr64 - 64'd1));
    hi     = req64 & above;
    pick64 = lsb_onehot((hi != '0) ? hi : req64);
  end

  assign pick     = pick64[W-1:0];
  assign pick_idx = IDX_W'(onehot_enc(pick64));
  assign pick_vld = |i_req;

endmodule

// File: rtl/mask_arb.sv
// Round-robin arbiter with sticky registered grant and last-winner pointer.
// Optional burst lock on i_lock is compiled in with MASK_ARB_LOCK_EN.
module mask_arb
  import mask_arb_pkg::*;
#(
  parameter  int W     = 4,
  localparam int IDX_W = idx_w(W)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [W-1:0]     i_req,
  input  logic             i_lock,
  input  logic             i_ack,
  output logic             o_gnt_vld,
  output logic [W-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx
);

  localparam logic [W-1:0] PTR_RST = W'(1) << rst_ptr_pos(W);

  state_t             state, state_nxt;
  logic [W-1:0]       ptr, ptr_nxt, gnt_r, gnt_nxt, sel_ptr, pick;
  logic [IDX_W-1:0]   idx_r, idx_nxt, pick_idx;
  logic               pick_vld, lock_hold;

`ifdef MASK_ARB_LOCK_EN
  assign lock_hold = i_lock && ((gnt_r & i_req) != '0);
`else
  logic unused_lock;
  assign unused_lock = i_lock;
  assign lock_hold   = 1'b0;
`endif

  // While granting, re-arbitration sees the pointer as if already advanced to gnt_r.
  assign sel_ptr = (state == GRANT) ? gnt_r : ptr;

  mask_arb_sel #(.W(W), .IDX_W(IDX_W)) u_sel (
    .i_req    (i_req),
    .ptr      (sel_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt_r;
    idx_nxt   = idx_r;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          gnt_nxt   = pick;
          idx_nxt   = pick_idx;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (i_ack && !lock_hold) begin
          ptr_nxt = gnt_r;
          if (pick_vld) begin
            gnt_nxt = pick;
            idx_nxt = pick_idx;
          end else begin
            gnt_nxt   = '0;
            idx_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      ptr   <= PTR_RST;
      gnt_r <= '0;
      idx_r <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt_r <= gnt_nxt;
      idx_r <= idx_nxt;
    end
  end

  assign o_gnt_vld = (state == GRANT);
  assign o_gnt     = gnt_r;
  assign o_gnt_idx = idx_r;

endmodule

// File: tb/tb_mask_arb.sv
// Bench for mask_arb: rotating-search reference model plus directed literal checks.
module tb_mask_arb;
  import mask_arb_pkg::*;

  localparam int W = 4;
  localparam int IDX_W = idx_w(W);
`ifdef MASK_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             arst;
  logic [W-1:0]     i_req;
  logic             i_lock, i_ack;
  logic             o_gnt_vld;
  logic [W-1:0]     o_gnt;
  logic [IDX_W-1:0] o_gnt_idx;

  int n_cmp = 0;
  int n_bad = 0;

  mask_arb #(.W(W)) dut (
    .clk       (clk),
    .arst      (arst),
    .i_req     (i_req),
    .i_lock    (i_lock),
    .i_ack     (i_ack),
    .o_gnt_vld (o_gnt_vld),
    .o_gnt     (o_gnt),
    .o_gnt_idx (o_gnt_idx)
  );

  always #5 clk = ~clk;

  // Reference model: grant state, plus index of the last accepted winner.
  typedef struct packed {
    bit vld;
    int idx;
    int last;
  } mst_t;

  mst_t m;

  // First requester found scanning upward from after+1, wrapping around.
  function automatic int pick(input logic [W-1:0] req, input int after);
    for (int k = 1; k <= W; k++) begin
      int j;
      j = (after + k) % W;
      if (((req >> j) & W'(1)) != '0) return j;
    end
    return -1;
  endfunction

  function automatic mst_t model_next(input mst_t s, input logic [W-1:0] req,
                                      input logic ack, input logic lk);
    mst_t n;
    int p;
    n = s;
    if (!s.vld) begin
      p = pick(req, s.last);
      if (p >= 0) begin
        n.vld = 1'b1;
        n.idx = p;
      end
    end else if (ack) begin
      if (!(LOCK_EN && lk && (((req >> s.idx) & W'(1)) != '0))) begin
        n.last = s.idx;
        p = pick(req, s.idx);
        if (p >= 0) n.idx = p;
        else begin
          n.vld = 1'b0;
          n.idx = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge arst) begin
    if (arst) m <= '{vld: 1'b0, idx: 0, last: W - 1};
    else      m <= model_next(m, i_req, i_ack, i_lock);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model comparison every cycle, away from the rising edge.
  always @(negedge clk) begin
    chk("m_vld", 64'(o_gnt_vld), 64'(m.vld));
    chk("m_idx", 64'(o_gnt_idx), 64'(m.idx));
    chk("m_gnt", 64'(o_gnt), m.vld ? (64'd1 << m.idx) : 64'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_g(input string nm, input bit v, input int idx);
    chk({nm, "_vld"}, 64'(o_gnt_vld), 64'(v));
    chk({nm, "_idx"}, 64'(o_gnt_idx), 64'(idx));
    chk({nm, "_gnt"}, 64'(o_gnt), v ? (64'd1 << idx) : 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rr_seq[5];
    int lk_seq[4];
    rr_seq = '{0, 1, 2, 3, 0};
`ifdef MASK_ARB_LOCK_EN
    lk_seq = '{1, 1, 1, 3};
`else
    lk_seq = '{3, 1, 3, 1};
`endif
    arst = 1'b1; i_req = '0; i_ack = 1'b0; i_lock = 1'b0;
    #11 exp_g("reset", 1'b0, 0);
    #1 arst = 1'b0;

    // All requesting with ack held: plain rotation, no bubbles.
    i_req = 4'b1111; i_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin step(); exp_g("rr", 1'b1, rr_seq[i]); end
    i_req = 4'b0000;
    step(); exp_g("rr_drain", 1'b0, 0);

    // Sticky grant survives request withdrawal until acked.
    i_req = 4'b0100; i_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin step(); exp_g("sticky", 1'b1, 2); end
    i_req = 4'b0000;
    for (int i = 0; i < 2; i++) begin step(); exp_g("sticky_drop", 1'b1, 2); end
    i_ack = 1'b1;
    step(); exp_g("sticky_ack", 1'b0, 0);
    step(); exp_g("idle_ack", 1'b0, 0);

    // Pointer wrap from last winner 3.
    i_req = 4'b1000; i_ack = 1'b0;
    step(); exp_g("wrap_setup", 1'b1, 3);
    i_req = 4'b0011; i_ack = 1'b1;
    step(); exp_g("wrap0", 1'b1, 0);
    step(); exp_g("wrap1", 1'b1, 1);
    i_req = 4'b0000;
    step(); exp_g("wrap_drain", 1'b0, 0);

    // Burst lock on index 1.
    i_req = 4'b0010; i_ack = 1'b0;
    step(); exp_g("lock_setup", 1'b1, 1);
    i_req = 4'b1010; i_lock = 1'b1; i_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); exp_g("lock", 1'b1, lk_seq[i]); end
    i_lock = 1'b0;
    step(); exp_g("lock_rel", 1'b1, lk_seq[3]);
    i_req = 4'b0000;
    step(); exp_g("lock_drain", 1'b0, 0);

    // Lock requested but granted bit dropped: behaves as unlocked.
    i_req = 4'b0010; i_ack = 1'b0;
    step(); exp_g("drop_setup", 1'b1, 1);
    i_req = 4'b1000; i_lock = 1'b1; i_ack = 1'b1;
    step(); exp_g("lock_drop", 1'b1, 3);
    i_lock = 1'b0; i_ack = 1'b0;
    step(); exp_g("pre_rst", 1'b1, 3);

    // Asynchronous reset mid-grant.
    arst = 1'b1;
    #1 exp_g("async_rst", 1'b0, 0);
    #2 arst = 1'b0;
    i_req = 4'b1000;
    step(); exp_g("post_rst", 1'b1, 3);
    i_req = 4'b1001; i_ack = 1'b1;
    step(); exp_g("post_rst_rr", 1'b1, 0);
    i_req = 4'b0000;
    step(); exp_g("final_drain", 1'b0, 0);

    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
